reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer_pkg.sv | 16 +
 rtl/reset_sequencer_stage_timer.sv | 30 +++
 rtl/reset_sequencer.sv | 106 ++++++++++
 tb/tb_reset_sequencer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer: state encoding and default timing.
package reset_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_HOLD  = 3'd0,
        ST_MEM   = 3'd1,
        ST_IO    = 3'd2,
        ST_RUN   = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    localparam int DEF_STAGE_DELAY = 16;
    localparam int DEF_TIMEOUT     = 1024;
    localparam int DEF_CNT_W       = 11;

endpackage

// File: rtl/reset_sequencer_stage_timer.sv
// Per-stage cycle counter: synchronous clear, enable, and terminal-count flag
// against a limit. It stops at the limit so it can never wrap.
module stage_timer
    import reset_sequencer_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             tc
);

    logic [CNT_W-1:0] count;

    assign tc = (count == limit);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !tc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release: memory, then I/O, then CPU, with per-stage timeout.
// Outputs are registered from the next-state decode so they change only on clk.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int STAGE_DELAY = DEF_STAGE_DELAY,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       soft_reset_req,
    input  logic       mem_ready,
    input  logic       io_ready,
    output logic       rst_mem,
    output logic       rst_io,
    output logic       rst_cpu,
    output logic       done,
    output logic       fault,
    output logic [2:0] state_dbg
);

    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(STAGE_DELAY - 1);
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(TIMEOUT - 1);

    state_t           state;
    state_t           next_state;
    logic             tc;
    logic             clear;
    logic             enable;
    logic [CNT_W-1:0] limit;
    logic             nxt_rst_mem, nxt_rst_io, nxt_rst_cpu, nxt_done, nxt_fault;

    stage_timer #(.CNT_W(CNT_W)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear),
        .enable (enable),
        .limit  (limit),
        .tc     (tc)
    );

    // Ready is tested before timeout so a same-cycle ready wins; soft reset overrides both.
    always_comb begin
        next_state = state;
        case (state)
            ST_HOLD:  if (tc) next_state = ST_MEM;
            ST_MEM:   if (mem_ready) next_state = ST_IO;
                      else if (tc) next_state = ST_FAULT;
            ST_IO:    if (io_ready) next_state = ST_RUN;
                      else if (tc) next_state = ST_FAULT;
            default:  next_state = state;
        endcase
        if (soft_reset_req) next_state = ST_HOLD;
    end

    always_comb begin
        limit  = (state == ST_HOLD) ? HOLD_LIMIT : WAIT_LIMIT;
        enable = (state == ST_HOLD) || (state == ST_MEM) || (state == ST_IO);
        clear  = soft_reset_req || (next_state != state);
    end

    always_comb begin
        nxt_rst_mem = 1'b1;
        nxt_rst_io  = 1'b1;
        nxt_rst_cpu = 1'b1;
        nxt_done    = 1'b0;
        nxt_fault   = 1'b0;
        case (next_state)
            ST_MEM: nxt_rst_mem = 1'b0;
            ST_IO: begin
                nxt_rst_mem = 1'b0;
                nxt_rst_io  = 1'b0;
            end
            ST_RUN: begin
                nxt_rst_mem = 1'b0;
                nxt_rst_io  = 1'b0;
                nxt_rst_cpu = 1'b0;
                nxt_done    = 1'b1;
            end
            ST_FAULT: nxt_fault = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_HOLD;
            rst_mem <= 1'b1;
            rst_io  <= 1'b1;
            rst_cpu <= 1'b1;
            done    <= 1'b0;
            fault   <= 1'b0;
        end else begin
            state   <= next_state;
            rst_mem <= nxt_rst_mem;
            rst_io  <= nxt_rst_io;
            rst_cpu <= nxt_rst_cpu;
            done    <= nxt_done;
            fault   <= nxt_fault;
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed timing scenarios plus random stimulus,
// compared every cycle against a stage/age reference model.
module tb_reset_sequencer;

    localparam int SD = 16;
    localparam int TO = 1024;

    logic       clk;
    logic       reset;
    logic       soft_reset_req;
    logic       mem_ready;
    logic       io_ready;
    logic       rst_mem, rst_io, rst_cpu, done, fault;
    logic [2:0] state_dbg;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: stage index (0 hold, 1 mem, 2 io, 3 run, 4 fault) and edges spent in it.
    int m_stage = 0;
    int m_age   = 0;

    reset_sequencer #(.STAGE_DELAY(SD), .TIMEOUT(TO), .CNT_W(11)) dut (
        .clk            (clk),
        .reset          (reset),
        .soft_reset_req (soft_reset_req),
        .mem_ready      (mem_ready),
        .io_ready       (io_ready),
        .rst_mem        (rst_mem),
        .rst_io         (rst_io),
        .rst_cpu        (rst_cpu),
        .done           (done),
        .fault          (fault),
        .state_dbg      (state_dbg)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // {rst_mem, rst_io, rst_cpu, done, fault} for each stage.
    function automatic logic [4:0] exp_outs(input int st);
        case (st)
            0:       return 5'b11100;
            1:       return 5'b01100;
            2:       return 5'b00100;
            3:       return 5'b00010;
            default: return 5'b11101;
        endcase
    endfunction

    task automatic model_edge(input logic s, input logic m, input logic i);
        if (s) begin
            m_stage = 0;
            m_age   = 0;
        end else begin
            case (m_stage)
                0: if (m_age + 1 == SD) begin m_stage = 1; m_age = 0; end
                   else m_age++;
                1: if (m) begin m_stage = 2; m_age = 0; end
                   else if (m_age + 1 >= TO) begin m_stage = 4; m_age = 0; end
                   else m_age++;
                2: if (i) begin m_stage = 3; m_age = 0; end
                   else if (m_age + 1 >= TO) begin m_stage = 4; m_age = 0; end
                   else m_age++;
                default: m_age++;
            endcase
        end
    endtask

    task automatic compare_all();
        logic [4:0] o;
        o = exp_outs(m_stage);
        check("state_dbg", 16'(state_dbg), 16'(m_stage));
        check("rst_mem",   16'(rst_mem),   16'(o[4]));
        check("rst_io",    16'(rst_io),    16'(o[3]));
        check("rst_cpu",   16'(rst_cpu),   16'(o[2]));
        check("done",      16'(done),      16'(o[1]));
        check("fault",     16'(fault),     16'(o[0]));
    endtask

    // Called at posedge+1: drive inputs, take one edge, update model, compare.
    task automatic step(input logic s, input logic m, input logic i);
        soft_reset_req = s;
        mem_ready      = m;
        io_ready       = i;
        @(posedge clk);
        model_edge(s, m, i);
        #1;
        compare_all();
    endtask

    // Asserts reset mid-cycle, checks the asynchronous effect, releases after the edge.
    task automatic do_reset();
        #10;
        reset = 1'b1;
        #1;
        m_stage = 0;
        m_age   = 0;
        compare_all();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        reset = 1'b0;
    endtask

    task automatic measure_falls(output int mf, output int iof, output int cf);
        mf = 0; iof = 0; cf = 0;
        for (int k = 1; k <= SD + 4; k++) begin
            step(1'b0, 1'b1, 1'b1);
            if (!rst_mem && mf == 0)  mf  = k;
            if (!rst_io  && iof == 0) iof = k;
            if (!rst_cpu && cf == 0)  cf  = k;
        end
    endtask

    initial begin
        int mf, iof, cf, fe;
        reset          = 1'b1;
        soft_reset_req = 1'b0;
        mem_ready      = 1'b0;
        io_ready       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        reset = 1'b0;

        // Power-up with both readys high.
        measure_falls(mf, iof, cf);
        check("pwr_mem_fall", 16'(mf),  16'(SD));
        check("pwr_io_fall",  16'(iof), 16'(SD + 1));
        check("pwr_cpu_fall", 16'(cf),  16'(SD + 2));
        check("pwr_done",     16'(done), 16'd1);

        // Soft reset held 10 cycles in RUN.
        repeat (10) step(1'b1, 1'b1, 1'b1);
        measure_falls(mf, iof, cf);
        check("soft_held_mem_fall", 16'(mf + 10), 16'(SD + 10));

        // Late mem_ready, then io timeout.
        do_reset();
        repeat (SD) step(1'b0, 1'b0, 1'b0);
        repeat (5) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("io_entry_rst_io", 16'(rst_io), 16'd0);
        fe = 0;
        for (int k = 1; k <= TO + 10 && fe == 0; k++) begin
            step(1'b0, 1'b0, 1'b0);
            if (fault) fe = k;
        end
        check("fault_edge", 16'(fe), 16'(TO));
        check("fault_rst_mem", 16'(rst_mem), 16'd1);

        // One-cycle soft reset out of FAULT, then the full sequence again.
        step(1'b1, 1'b0, 1'b0);
        check("fault_cleared", 16'(fault), 16'd0);
        measure_falls(mf, iof, cf);
        check("rerun_mem_fall", 16'(mf),  16'(SD));
        check("rerun_io_fall",  16'(iof), 16'(SD + 1));
        check("rerun_cpu_fall", 16'(cf),  16'(SD + 2));

        // mem_ready arriving on the last count before timeout.
        do_reset();
        repeat (SD) step(1'b0, 1'b0, 1'b0);
        repeat (TO - 1) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("late_ready_state", 16'(state_dbg), 16'd2);
        check("late_ready_fault", 16'(fault), 16'd0);

        // Asynchronous reset while in IO.
        do_reset();
        repeat (SD + 3) step(1'b0, 1'b1, 1'b0);
        check("in_io_before_rst", 16'(state_dbg), 16'd2);
        do_reset();
        check("async_rst_done", 16'(done), 16'd0);

        // Random traffic.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 99) < 3,
                     $urandom_range(0, 7) == 0,
                     $urandom_range(0, 7) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
